// File: rtl/mips_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multi_ctrl
// Description : Multicycle MIPS control sequencer. Steps each instruction
//               through fetch/decode/execute/memory/write-back, drives the
//               datapath selects and strobes, and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multi_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic [1:0]       pc_src_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_ctrl_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        EXEC    = 4'd6,
        ALU_WB  = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        HALT    = 4'd10
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;
    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_SUB   = 6'd34;
    localparam logic [5:0] c_FN_AND   = 6'd36;
    localparam logic [5:0] c_FN_OR    = 6'd37;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_retire;
    logic             w_rtype_ok;

    assign w_rtype_ok = (funct_i == c_FN_ADD) || (funct_i == c_FN_SUB) ||
                        (funct_i == c_FN_AND) || (funct_i == c_FN_OR);

    // State, sticky illegal flag and retire counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next-state decode and per-state datapath controls; reset forces all outputs low
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        w_retire     = 1'b0;
        pc_en_o      = 1'b0;
        pc_src_o     = 2'b00;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = 3'b010;
        case (state_q)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_en_o     = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                if (opcode_i == c_OP_LW || opcode_i == c_OP_SW)   state_d = MEM_ADR;
                else if (opcode_i == c_OP_RTYPE && w_rtype_ok)    state_d = EXEC;
                else if (opcode_i == c_OP_BEQ)                    state_d = BRANCH;
                else if (opcode_i == c_OP_J)                      state_d = JUMP;
                else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            MEM_ADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (opcode_i == c_OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
                if (mem_ready_i) state_d = MEM_WB;
            end
            MEM_WB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                w_retire     = 1'b1;
                state_d      = FETCH;
            end
            MEM_WR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) begin
                    w_retire = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXEC: begin
                alu_src_a_o = 1'b1;
                case (funct_i)
                    c_FN_SUB: alu_ctrl_o = 3'b110;
                    c_FN_AND: alu_ctrl_o = 3'b000;
                    c_FN_OR:  alu_ctrl_o = 3'b001;
                    default:  alu_ctrl_o = 3'b010;
                endcase
                state_d = ALU_WB;
            end
            ALU_WB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
                w_retire    = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = 3'b110;
                pc_src_o    = 2'b01;
                pc_en_o     = zero_i;
                w_retire    = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src_o = 2'b10;
                pc_en_o  = 1'b1;
                w_retire = 1'b1;
                state_d  = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        count_d = w_retire ? (count_q + CNT_W'(1)) : count_q;
        // Abandon any in-flight access immediately while reset is held
        if (rst) begin
            pc_en_o      = 1'b0;
            pc_src_o     = 2'b00;
            iord_o       = 1'b0;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            ir_write_o   = 1'b0;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = 2'b00;
            alu_ctrl_o   = 3'b000;
        end
    end

    assign state_o       = state_q;
    assign illegal_o     = illegal_q;
    assign instr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multi_ctrl
// Description : Directed self-checking bench for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multi_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode, funct;
    logic             zero, mem_ready;
    logic             pc_en, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]       pc_src, alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    int vecs = 0;
    int errs = 0;
    int exp_cnt;
    int n_a, n_b;

    mips_multi_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .opcode_i(opcode), .funct_i(funct), .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_en_o(pc_en), .pc_src_o(pc_src), .iord_o(iord),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_ctrl_o(alu_ctrl),
        .illegal_o(illegal), .state_o(state), .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full clock; returns just after the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {pc_en, ir_write, mem_read, mem_write, reg_write};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv[4]     = '{32, 34, 36, 37};
        int av[4]     = '{2, 6, 0, 1};
        int lw_mr[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        int lw_st[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        int sw_mr[7]  = '{1, 1, 1, 0, 0, 0, 1};
        int sw_st[7]  = '{0, 1, 2, 5, 5, 5, 5};

        rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("reset_state", state, 0);
        chk("reset_count", instr_count, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_strobes", strobes(), 0);

        // Reset in the middle of a load's memory read
        rst = 1'b0; opcode = 6'd35; mem_ready = 1'b1; #1;
        tick(); chk("lw0_decode", state, 1);
        tick(); chk("lw0_memadr", state, 2);
        tick(); mem_ready = 1'b0; #1;
        chk("lw0_memrd", state, 3);
        chk("lw0_memrd_read", {iord, mem_read}, 2'b11);
        tick(); chk("lw0_memrd_hold", {state, iord, mem_read}, {4'd3, 2'b11});
        rst = 1'b1; #1;
        chk("midrst_read", mem_read, 0);
        chk("midrst_iord", iord, 0);
        chk("midrst_state", state, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("postrst_state", state, 0);
        chk("postrst_count", instr_count, 0);
        exp_cnt = 0;

        // R-type sequence ADD, SUB, AND, OR
        opcode = 6'd0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            funct = fv[i][5:0]; #1;
            chk("rt_fetch", {state, ir_write, pc_en, mem_read, alu_src_b}, {4'd0, 3'b111, 2'b01});
            tick(); chk("rt_decode", {state, alu_src_a, alu_src_b}, {4'd1, 1'b0, 2'b11});
            tick(); chk("rt_exec", {state, alu_src_a, alu_src_b}, {4'd6, 1'b1, 2'b00});
            chk("rt_aluctrl", alu_ctrl, av[i]);
            tick(); chk("rt_aluwb", {state, reg_write, reg_dst, mem_to_reg}, {4'd7, 3'b110});
            tick(); exp_cnt++;
            chk("rt_count", instr_count, exp_cnt);
        end

        // LW with two fetch stalls and three read stalls
        opcode = 6'd35; n_a = 0; n_b = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = lw_mr[c][0]; #1;
            chk("lw_state", state, lw_st[c]);
            if (lw_st[c] == 3) chk("lw_rd_strobe", {iord, mem_read}, 2'b11);
            if (lw_st[c] == 0) chk("lw_fetch_strobe", {iord, mem_read}, 2'b01);
            if (ir_write) n_a++;
            if (reg_write && mem_to_reg) n_b++;
            tick();
        end
        exp_cnt++;
        chk("lw_end_state", state, 0);
        chk("lw_irwrite_pulses", n_a, 1);
        chk("lw_wb_pulses", n_b, 1);
        chk("lw_count", instr_count, exp_cnt);

        // SW with three write stalls
        opcode = 6'd43; n_a = 0; n_b = 0;
        for (int c = 0; c < 7; c++) begin
            mem_ready = sw_mr[c][0]; #1;
            chk("sw_state", state, sw_st[c]);
            if (mem_write) n_a++;
            if (reg_write) n_b++;
            tick();
        end
        exp_cnt++;
        chk("sw_end_state", state, 0);
        chk("sw_write_cycles", n_a, 4);
        chk("sw_regwrite_cycles", n_b, 0);
        chk("sw_count", instr_count, exp_cnt);

        // BEQ taken, BEQ not taken
        opcode = 6'd4; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0]; #1;
            chk("beq_fetch", state, 0);
            tick(); chk("beq_decode", state, 1);
            tick(); chk("beq_branch", {state, pc_src, alu_ctrl, alu_src_a}, {4'd8, 2'b01, 3'b110, 1'b1});
            chk("beq_pc_en", pc_en, z);
            tick(); exp_cnt++;
            chk("beq_count", {state, instr_count}, {4'd0, 4'(exp_cnt)});
        end

        // Jump
        opcode = 6'd2; zero = 1'b0; #1;
        tick(); tick();
        chk("j_jump", {state, pc_src, pc_en}, {4'd9, 2'b10, 1'b1});
        tick(); exp_cnt++;
        chk("j_count", {state, instr_count}, {4'd0, 4'(exp_cnt)});

        // Counter wrap: reset then 17 jumps on a 4-bit counter
        rst = 1'b1; #1;
        chk("wrap_reset_count", instr_count, 0);
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick(); tick(); tick();
        end
        chk("wrap_count", instr_count, 1);
        chk("wrap_state", state, 0);

        // Unsupported opcode halts permanently
        opcode = 6'h08; #1;
        chk("ill_fetch", state, 0);
        tick(); chk("ill_decode", {state, illegal}, {4'd1, 1'b0});
        tick(); chk("ill_halt", {state, illegal}, {4'd10, 1'b1});
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0]; zero = k[1]; #1;
            chk("halt_hold", {state, illegal, strobes(), instr_count}, {4'd10, 1'b1, 5'b00000, 4'd1});
            tick();
        end
        rst = 1'b1; #1;
        chk("ill_cleared", {illegal, state}, {1'b0, 4'd0});
        @(negedge clk); rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multi_ctrl.md
# mips_multi_ctrl

Multicycle control sequencer for the MIPS datapath: steps each instruction through fetch, decode, execute, memory and write-back states, and drives every mux select and write strobe of a shared-memory multicycle datapath (PC, IR, register file, ALU, unified memory). It supports ADD, SUB, AND, OR, LW, SW, BEQ and J, and waits on a memory-ready handshake. It halts on any other instruction and counts retired instructions for the CPU testbench.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (A − B == 0)
- mem_ready  in  1  memory completes current access this cycle
- pc_en  out  1  PC write enable
- pc_src  out  2  00 ALU result, 01 ALUOut reg, 10 jump target {PC[31:28],IR[25:0],00}
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load enable
- reg_dst  out  1  dest reg: 0 rt, 1 rd
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or
- illegal  out  1  sticky, unsupported instruction decoded
- state  out  4  current state code (debug)
- instr_count  out  CNT_W  retired instructions

## Operation
- States/codes: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, ALU_WB 7, BRANCH 8, JUMP 9, HALT 10.
- Unlisted outputs in a state are 0. alu_ctrl defaults to 010.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00. ir_write=pc_en=mem_ready. Stay while !mem_ready; else → DECODE.
- DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state:
  - opcode 35/43 → MEM_ADR
  - opcode 0 with funct 32/34/36/37 → EXEC
  - opcode 4 → BRANCH
  - opcode 2 → JUMP
  - else → HALT, set illegal
- MEM_ADR: alu_src_a=1, alu_src_b=10. opcode 35 → MEM_RD, else → MEM_WR.
- MEM_RD: iord=1, mem_read=1. Hold until mem_ready, then → MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
- MEM_WR: iord=1, mem_write=1. Hold until mem_ready, then → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (32→010, 34→110, 36→000, 37→001) → ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_en=zero → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- HALT: all strobes 0. Remain until rst.
- Retire: instr_count += 1 on the edge leaving MEM_WB, MEM_WR (with mem_ready), ALU_WB, BRANCH or JUMP. Wraps modulo 2^CNT_W. HALT never retires.
- opcode/funct are sampled only in DECODE, MEM_ADR and EXEC. IR is stable after FETCH.

## Timing
- Reset, asynchronous: state=FETCH, instr_count=0, illegal=0.
- While rst=1, every strobe output is forced to 0 combinationally (pc_en, ir_write, mem_read, mem_write, reg_write), and all selects are 0. This holds even mid-access; the in-flight operation is abandoned.
- Strobes are combinational from state plus mem_ready/zero. state, illegal and instr_count are registered.
- Cycles per instruction with mem_ready tied 1: R-type 4, LW 5, SW 4, BEQ 3, J 3.
- Each cycle mem_ready is low adds one cycle in FETCH/MEM_RD/MEM_WR. Strobes stay asserted and iord stays stable throughout the wait.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- illegal rises on the edge DECODE→HALT and stays 1 until rst.

## Test plan
- Reset mid-MEM_RD with mem_ready=0: assert rst → same cycle mem_read=0, state=0. After release, FETCH with instr_count=0.
- mem_ready=1, program ADD,SUB,AND,OR → states 0,1,6,7 each. alu_ctrl in EXEC = 010,110,000,001. reg_write=1, reg_dst=1 in ALU_WB. instr_count=4 after 16 cycles.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM_RD → 10 cycles total, ir_write single-cycle pulse, reg_write=1 with mem_to_reg=1 once. SW → mem_write held 4 cycles, reg_write never 1.
- BEQ zero=1 → pc_en=1, pc_src=01 in state 8. BEQ zero=0 → pc_en=0. Both retire (count+1) in 3 cycles. J → pc_src=10, pc_en=1.
- opcode 6'h08 (addi) → DECODE→HALT, illegal=1, all strobes 0 for 20 cycles, instr_count frozen.
- CNT_W=4: run 17 J instructions → instr_count wraps to 1.
